fetch_stage: RTL and testbench

Instruction fetch stage for the RV32I core. It owns the program counter and drives the synchronous instruction memory. It presents one 32-bit instruction plus its PC per cycle to the control/decode stage over a valid/ready handshake. Taken branches and jumps arrive as a redirect from execute; on a redirect the stage flushes all wrong-path instructions and restarts fetch at the target.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 66 ++++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: reset PC, the canonical NOP encoding and
// the {instruction, pc} record that moves between fetch and decode.
package riscv_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_2000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instructions. Entry 0 is always the head;
// flush empties the buffer and overrides any push or pop in that cycle.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  logic [1:0]   count_q, count_d;
  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic         do_pop;
  logic         do_push;
  logic [1:0]   slot;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q < 2'(DEPTH)) || do_pop);
  assign slot    = count_q - {1'b0, do_pop};

  always_comb begin
    count_d  = count_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      // Popping shifts entry 1 forward; a simultaneous push lands behind it.
      if (do_pop) begin
        entry0_d = entry1_q;
      end
      if (do_push) begin
        if (slot == 2'd0) begin
          entry0_d = push_data;
        end else begin
          entry1_d = push_data;
        end
      end
      count_d = slot + {1'b0, do_push};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      entry0_q <= '{inst: INST_NOP, pc: PC_RESET_DEFAULT};
      entry1_q <= '{inst: INST_NOP, pc: PC_RESET_DEFAULT};
    end else begin
      count_q  <= count_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, drives the synchronous instruction
// memory and hands {inst, pc} to decode over valid/ready, flushing on redirect.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         inflight_q, inflight_d;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         pop;
  logic         push;
  logic         fifo_pop;
  logic [2:0]   occupancy;
  logic [31:0]  target;

  assign target = redirect_pc & 32'hFFFF_FFFC;

  // Head is the buffered entry if any, else the word returning from memory.
  always_comb begin
    inst_valid = ((count != 2'd0) || inflight_q) && !redirect;
    if (count != 2'd0) begin
      inst    = head.inst;
      inst_pc = head.pc;
    end else if (inflight_q) begin
      inst    = imem_dout;
      inst_pc = req_pc_q;
    end else begin
      inst    = INST_NOP;
      inst_pc = RESET_PC;
    end
  end

  always_comb begin
    pop            = inst_valid && inst_ready;
    fifo_pop       = pop && (count != 2'd0);
    push           = inflight_q && !redirect && !((count == 2'd0) && pop);
    push_data.inst = imem_dout;
    push_data.pc   = req_pc_q;
    occupancy      = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
    // Issue only when the returning word is guaranteed a free slot.
    imem_en        = !rst && (redirect || (occupancy < 3'(BUF_DEPTH)));
    imem_addr      = (!rst && redirect) ? target : pc_q;
    pc_d           = imem_en ? (imem_addr + 32'd4) : pc_q;
    req_pc_d       = imem_en ? imem_addr : req_pc_q;
    inflight_d     = imem_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (fifo_pop),
    .flush    (redirect),
    .push_data(push_data),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues the expected accepted
// {pc, inst} stream, an independent monitor checks every accepted instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t expq[$];
  exp_t monEntry;
  int   errors = 0;
  int   checks = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_dout  (imem_dout),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC001_0013;
  endfunction

  // Synchronous instruction memory: data appears the cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_dout <= memWord(imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = memWord(pc);
    expq.push_back(e);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    checkOutput({tag, "_imem_en"},    {31'b0, imem_en},    32'd0);
    checkOutput({tag, "_imem_addr"},  imem_addr,           32'h0000_2000);
    checkOutput({tag, "_inst"},       inst,                32'h0000_0013);
    checkOutput({tag, "_inst_pc"},    inst_pc,             32'h0000_2000);
  endtask

  // Monitor: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop: got pc %h, expected no instruction", inst_pc);
      end else begin
        monEntry = expq.pop_front();
        checkOutput("pop_pc", inst_pc, monEntry.pc);
        checkOutput("pop_inst", inst, monEntry.inst);
      end
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #1;

    // Streaming from the reset vector.
    for (int i = 0; i < 8; i++) expectPc(32'h0000_2000 + 32'(i) * 32'd4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("first_imem_en", {31'b0, imem_en}, 32'd1);
    checkOutput("first_imem_addr", imem_addr, 32'h0000_2000);
    checkOutput("first_valid_low", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    checkOutput("first_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("first_inst_pc", inst_pc, 32'h0000_2000);
    repeat (7) @(negedge clk);
    tick();

    // Backpressure: decode stalls four cycles.
    expectPc(32'h0000_2020);
    expectPc(32'h0000_2024);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_inst_pc", inst_pc, 32'h0000_2020);
      checkOutput("bp_inst", inst, memWord(32'h0000_2020));
      checkOutput("bp_imem_en", {31'b0, imem_en}, (i == 0) ? 32'd1 : 32'd0);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("release_imem_en", {31'b0, imem_en}, 32'd1);
    checkOutput("release_imem_addr", imem_addr, 32'h0000_2028);
    @(negedge clk);
    tick();

    // Fill the buffer, then redirect to a misaligned target.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("full_imem_en", {31'b0, imem_en}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_3003, 1'b0);
    expectPc(32'h0000_3000);
    expectPc(32'h0000_3004);
    expectPc(32'h0000_3008);
    @(negedge clk);
    checkOutput("redir_imem_en", {31'b0, imem_en}, 32'd1);
    checkOutput("redir_imem_addr", imem_addr, 32'h0000_3000);
    checkOutput("redir_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("redir_lat_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("redir_lat_pc", inst_pc, 32'h0000_3000);
    repeat (2) @(negedge clk);
    tick();

    // Redirect while decode is ready and one entry is buffered.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b1);
    expectPc(32'h0000_4000);
    expectPc(32'h0000_4004);
    @(negedge clk);
    checkOutput("hs_redir_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("hs_redir_addr", imem_addr, 32'h0000_4000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    tick();

    // Wrap-around of the 32-bit PC.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    expectPc(32'hFFFF_FFFC);
    expectPc(32'h0000_0000);
    expectPc(32'h0000_0004);
    @(negedge clk);
    checkOutput("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    tick();

    // Asynchronous reset with a simultaneous redirect.
    applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) expectPc(32'h0000_2000 + 32'(i) * 32'd4);
    @(negedge clk);
    checkOutput("resume_imem_en", {31'b0, imem_en}, 32'd1);
    checkOutput("resume_imem_addr", imem_addr, 32'h0000_2000);
    for (int i = 0; i < 20 && expq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("drain_remaining", 32'(expq.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
